mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer that drives one mac_mult_block_0-style multiply block to compute a dot product over a length-N operand stream. It latches a per-job configuration, accepts operand beats via valid/ready, and drives registered operands to the multiplier. It accumulates the multiplier result into a wide accumulator and presents the final sum on a valid/ready output. It sits between the operand fetch logic and the fabric result path.

Parameters:
ACC_W, 48, accumulator and result width; the product is zero-extended or truncated to ACC_W.
LEN_W, 16, width of the job length field.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  job start pulse; sampled only in IDLE
cfg_in  in  `MAC_CONF_WIDTH  job config; cfg_in[1:0] is `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD
len_in  in  LEN_W  number of operand beats in the job
abort  in  1  synchronous job cancel
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse on start with an unsupported cfg_in[1:0]
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
in_a  in  4*`MAC_MIN_WIDTH  {A3,A2,A1,A0}
in_b  in  `MAC_MIN_WIDTH  B0
mul_en  out  1  stage-1 operands valid
mul_cfg  out  `MAC_CONF_WIDTH  latched job cfg
mul_a0..mul_a3  out  `MAC_MIN_WIDTH each  registered A lanes
mul_b0  out  `MAC_MIN_WIDTH  registered B
mul_c  in  `MAC_INT_WIDTH  combinational product from the multiply block
out_valid  out  1  result valid
out_ready  in  1  result accepted when out_valid && out_ready
out_acc  out  ACC_W  accumulated sum
out_ovf  out  1  sticky: a carry-out occurred during the job

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs 0, including the mul_* registers.
  - Accumulator, beat counter, latched cfg and latched len cleared.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - in_ready=0.
  - start with cfg_in[1:0] in {SINGLE, DUAL, QUAD}: latch cfg and len, clear acc and ovf, clear counter.
    - Go to RUN if len_in != 0.
    - Go directly to OUT with acc=0 if len_in == 0.
  - start with any other cfg: cfg_err=1 for one cycle; remain in IDLE.
- RUN:
  - in_ready=1.
  - Each handshake loads the stage-1 registers and sets mul_en=1 for the following cycle; the counter increments.
  - Lane masking applied at load: SINGLE zeroes A1..A3; DUAL zeroes A2..A3; QUAD passes all lanes.
  - The handshake that makes count == len moves the state to DRAIN.
  - A cycle without a handshake loads nothing, so mul_en=0 in the next cycle.
- Accumulate: every cycle with mul_en=1, at the next clock edge acc <= acc + mul_c (width-adjusted), modulo 2^ACC_W.
  - A carry-out of the add sets ovf.
- DRAIN: in_ready=0; one cycle; the final product accumulates; go to OUT.
- OUT:
  - out_valid=1; out_acc and out_ovf are held stable until out_ready.
  - On handshake: go to IDLE; out_valid drops next cycle; acc is not cleared until the next start.
- Latency: if the last beat is accepted at edge t, out_valid is high after edge t+2.
  - Minimum job: len=1 means 3 cycles from the beat to the result.
- start outside IDLE: ignored; no error.
- abort: any state goes to IDLE at the next edge.
  - mul_en, out_valid and in_ready drop; acc and ovf cleared.
  - abort has priority over every other event in the same cycle.
- Simultaneous out_ready and start in OUT: start is ignored because the state is not yet IDLE.
- Reset mid-job: the job is discarded; no partial result is ever presented.
- Counter saturation: impossible by construction, because the counter width is LEN_W and the compare is exact.

Decomposition:
- Shared header mac_const.vh supplies `MAC_MIN_WIDTH, `MAC_INT_WIDTH, `MAC_CONF_WIDTH and `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD.
- Add to the same header: state encodings `MAC_SEQ_IDLE/RUN/DRAIN/OUT (2 bits).
- One natural sub-module, mac_seq_acc: the accumulator with overflow detect and clear/enable.
- The FSM, counter and operand stage stay in mac_seq_ctrl.
- The multiply block is instantiated by the parent, not inside this block.

Test Plan (MIN_WIDTH=8, multiply block connected):
1. SINGLE, len=2, beats (A0=3,B=5), (A0=6,B=4), back-to-back, out_ready=1 -> out_acc=39, out_ovf=0; out_valid 2 cycles after the second beat.
2. DUAL, len=2, in_a=0x0000_0102, in_b=3 both beats, with in_valid gapped one cycle between beats -> out_acc=1548; mul_a2/mul_a3=0 throughout.
3. QUAD, len=1, in_a=0xFFFF_FFFF, in_b=0xFF; out_ready held low 5 cycles -> out_acc=0xFE_FFFF_FF01 stable across the stall; one handshake; then IDLE.
4. ACC_W=16, SINGLE, len=2, beats (255,255)x2 -> out_acc=64514, out_ovf=1.
5. start with len=0 -> out_valid 1 cycle later, out_acc=0. start with cfg_in[1:0] unsupported -> cfg_err pulse, busy stays 0.
6. abort asserted in RUN after 1 of 4 beats -> IDLE next cycle, in_ready=0, no out_valid. A new SINGLE len=1 job (2,2) then gives out_acc=4.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// rtl/mac_seq_ctrl_pkg.sv - shared constants, state encoding and lane helpers for the MAC sequencer
`ifndef MAC_CONST_VH
`define MAC_CONST_VH
`define MAC_MIN_WIDTH  8
`define MAC_INT_WIDTH  40
`define MAC_CONF_WIDTH 4
`define MAC_SINGLE     2'd0
`define MAC_DUAL       2'd1
`define MAC_QUAD       2'd2
`define MAC_SEQ_IDLE   2'd0
`define MAC_SEQ_RUN    2'd1
`define MAC_SEQ_DRAIN  2'd2
`define MAC_SEQ_OUT    2'd3
`endif

package mac_seq_ctrl_pkg;
    localparam int MAC_MIN_WIDTH  = `MAC_MIN_WIDTH;
    localparam int MAC_INT_WIDTH  = `MAC_INT_WIDTH;
    localparam int MAC_CONF_WIDTH = `MAC_CONF_WIDTH;

    localparam logic [1:0] MAC_SINGLE = `MAC_SINGLE;
    localparam logic [1:0] MAC_DUAL   = `MAC_DUAL;
    localparam logic [1:0] MAC_QUAD   = `MAC_QUAD;

    typedef enum logic [1:0] {
        ST_IDLE  = `MAC_SEQ_IDLE,
        ST_RUN   = `MAC_SEQ_RUN,
        ST_DRAIN = `MAC_SEQ_DRAIN,
        ST_OUT   = `MAC_SEQ_OUT
    } seq_state_e;

    function automatic logic cfg_supported(input logic [1:0] mode);
        return (mode == MAC_SINGLE) || (mode == MAC_DUAL) || (mode == MAC_QUAD);
    endfunction

    // Lanes above the active width are forced to zero so the multiplier sees a clean operand.
    function automatic logic [4*MAC_MIN_WIDTH-1:0] lane_mask(
        input logic [4*MAC_MIN_WIDTH-1:0] a,
        input logic [1:0]                 mode
    );
        logic [4*MAC_MIN_WIDTH-1:0] m;
        m = a;
        if (mode == MAC_SINGLE)
            m[4*MAC_MIN_WIDTH-1:MAC_MIN_WIDTH] = '0;
        else if (mode == MAC_DUAL)
            m[4*MAC_MIN_WIDTH-1:2*MAC_MIN_WIDTH] = '0;
        return m;
    endfunction
endpackage

// File: rtl/mac_seq_acc.sv
// rtl/mac_seq_acc.sv - wide accumulator with clear, enable and sticky carry-out
module mac_seq_acc #(
    parameter int ACC_W = 48,
    parameter int IN_W  = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  add_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W-1:0] add_ext;
    logic [ACC_W:0]   sum_d;

    generate
        if (IN_W >= ACC_W) begin : g_trunc
            logic unused_hi;
            assign add_ext   = add_i[ACC_W-1:0];
            assign unused_hi = ^add_i;
        end else begin : g_zext
            assign add_ext = {{(ACC_W-IN_W){1'b0}}, add_i};
        end
    endgenerate

    assign sum_d = {1'b0, acc_q} + {1'b0, add_ext};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= sum_d[ACC_W-1:0];
            ovf_q <= ovf_q | sum_d[ACC_W];
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer feeding an external multiply block
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int LEN_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MAC_CONF_WIDTH-1:0]   cfg_in,
    input  logic [LEN_W-1:0]            len_in,
    input  logic                        abort,
    output logic                        busy,
    output logic                        cfg_err,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0]  in_a,
    input  logic [MAC_MIN_WIDTH-1:0]    in_b,
    output logic                        mul_en,
    output logic [MAC_CONF_WIDTH-1:0]   mul_cfg,
    output logic [MAC_MIN_WIDTH-1:0]    mul_a0,
    output logic [MAC_MIN_WIDTH-1:0]    mul_a1,
    output logic [MAC_MIN_WIDTH-1:0]    mul_a2,
    output logic [MAC_MIN_WIDTH-1:0]    mul_a3,
    output logic [MAC_MIN_WIDTH-1:0]    mul_b0,
    input  logic [MAC_INT_WIDTH-1:0]    mul_c,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_acc,
    output logic                        out_ovf
);
    seq_state_e                 state_q;
    logic [LEN_W-1:0]           cnt_q, len_q, cnt_d;
    logic [MAC_CONF_WIDTH-1:0]  cfg_q;
    logic                       mul_en_q, out_valid_q, cfg_err_q;
    logic [4*MAC_MIN_WIDTH-1:0] a_q;
    logic [MAC_MIN_WIDTH-1:0]   b_q;
    logic                       start_ok, acc_clr;

    assign cnt_d    = cnt_q + 1'b1;
    assign start_ok = (state_q == ST_IDLE) && start && cfg_supported(cfg_in[1:0]);
    assign acc_clr  = abort || start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            cfg_q       <= '0;
            mul_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            mul_en_q  <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        if (cfg_supported(cfg_in[1:0])) begin
                            cfg_q   <= cfg_in;
                            len_q   <= len_in;
                            cnt_q   <= '0;
                            state_q <= (len_in == '0) ? ST_OUT : ST_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    ST_RUN: if (in_valid) begin
                        a_q      <= lane_mask(in_a, cfg_q[1:0]);
                        b_q      <= in_b;
                        mul_en_q <= 1'b1;
                        cnt_q    <= cnt_d;
                        if (cnt_d == len_q)
                            state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: state_q <= ST_OUT;
                    // First OUT cycle lets the last sum settle before it is presented.
                    ST_OUT: begin
                        if (out_valid_q && out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    mac_seq_acc #(
        .ACC_W (ACC_W),
        .IN_W  (MAC_INT_WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (mul_en_q),
        .add_i (mul_c),
        .acc_o (out_acc),
        .ovf_o (out_ovf)
    );

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_RUN);
    assign cfg_err   = cfg_err_q;
    assign mul_en    = mul_en_q;
    assign mul_cfg   = cfg_q;
    assign mul_a0    = a_q[MAC_MIN_WIDTH-1:0];
    assign mul_a1    = a_q[2*MAC_MIN_WIDTH-1:MAC_MIN_WIDTH];
    assign mul_a2    = a_q[3*MAC_MIN_WIDTH-1:2*MAC_MIN_WIDTH];
    assign mul_a3    = a_q[4*MAC_MIN_WIDTH-1:3*MAC_MIN_WIDTH];
    assign mul_b0    = b_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl at ACC_W 48 and 16
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start, abort, in_valid, out_ready, sel;
    logic [3:0]  cfg_in;
    logic [15:0] len_in;
    logic [31:0] in_a;
    logic [7:0]  in_b;

    logic busy48, cerr48, rdy48, men48, ov48, ovf48;
    logic busy16, cerr16, rdy16, men16, ov16, ovf16;
    logic [3:0]  mcfg48, mcfg16;
    logic [7:0]  a0_48, a1_48, a2_48, a3_48, b_48, a0_16, a1_16, a2_16, a3_16, b_16;
    logic [39:0] mc48, mc16;
    logic [47:0] acc48;
    logic [15:0] acc16;

    assign mc48 = {a3_48, a2_48, a1_48, a0_48} * b_48;
    assign mc16 = {a3_16, a2_16, a1_16, a0_16} * b_16;

    mac_seq_ctrl #(.ACC_W(48), .LEN_W(16)) u48 (
        .clk(clk), .rst(rst), .start(start && !sel), .cfg_in(cfg_in), .len_in(len_in),
        .abort(abort), .busy(busy48), .cfg_err(cerr48), .in_valid(in_valid && !sel),
        .in_ready(rdy48), .in_a(in_a), .in_b(in_b), .mul_en(men48), .mul_cfg(mcfg48),
        .mul_a0(a0_48), .mul_a1(a1_48), .mul_a2(a2_48), .mul_a3(a3_48), .mul_b0(b_48),
        .mul_c(mc48), .out_valid(ov48), .out_ready(out_ready), .out_acc(acc48), .out_ovf(ovf48)
    );

    mac_seq_ctrl #(.ACC_W(16), .LEN_W(16)) u16 (
        .clk(clk), .rst(rst), .start(start && sel), .cfg_in(cfg_in), .len_in(len_in),
        .abort(abort), .busy(busy16), .cfg_err(cerr16), .in_valid(in_valid && sel),
        .in_ready(rdy16), .in_a(in_a), .in_b(in_b), .mul_en(men16), .mul_cfg(mcfg16),
        .mul_a0(a0_16), .mul_a1(a1_16), .mul_a2(a2_16), .mul_a3(a3_16), .mul_b0(b_16),
        .mul_c(mc16), .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16), .out_ovf(ovf16)
    );

    typedef struct {
        logic [47:0] acc;
        logic        ovf;
        int          ref_cyc;
        int          lat;
    } exp_t;

    exp_t exp48[$];
    exp_t exp16[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   dual_viol = 0;
    bit   chk_dual = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic pop_cmp(input bit w16, input logic [47:0] acc, input logic ovf,
                           input logic [47:0] racc, input int rcyc);
        exp_t e;
        if ((w16 && exp16.size() == 0) || (!w16 && exp48.size() == 0)) begin
            chk(w16 ? "unexpected_result16" : "unexpected_result48", 64'(acc), 64'hdead);
        end else begin
            e = w16 ? exp16.pop_front() : exp48.pop_front();
            chk(w16 ? "out_acc16" : "out_acc48", 64'(acc), 64'(e.acc));
            chk(w16 ? "out_ovf16" : "out_ovf48", 64'(ovf), 64'(e.ovf));
            chk("acc_stable", 64'(racc), 64'(acc));
            if (e.lat >= 0) chk("latency", 64'(rcyc - e.ref_cyc), 64'(e.lat));
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every result handshake.
    initial begin
        logic        p48, p16;
        logic [47:0] ra48, ra16;
        int          rc48, rc16;
        p48 = 0; p16 = 0; ra48 = 0; ra16 = 0; rc48 = 0; rc16 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_dual && men48 && (a2_48 != 0 || a3_48 != 0)) dual_viol++;
                if (ov48 && !p48) begin ra48 = acc48; rc48 = cyc; end
                if (ov16 && !p16) begin ra16 = 48'(acc16); rc16 = cyc; end
                if (ov48 && out_ready) pop_cmp(0, acc48, ovf48, ra48, rc48);
                if (ov16 && out_ready) pop_cmp(1, 48'(acc16), ovf16, ra16, rc16);
            end
            p48 = ov48;
            p16 = ov16;
        end
    end

    task automatic do_start(input logic [3:0] cfg, input logic [15:0] len, output int s);
        start = 1; cfg_in = cfg; len_in = len;
        @(posedge clk); #1;
        s = cyc;
        start = 0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [7:0] b, output int hs);
        bit done;
        done = 0; hs = -1;
        in_valid = 1; in_a = a; in_b = b;
        for (int i = 0; i < 20 && !done; i++) begin
            done = sel ? rdy16 : rdy48;
            @(posedge clk); #1;
            if (done) hs = cyc;
        end
        in_valid = 0;
        if (!done) chk("beat_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (sel ? (!busy16 && !ov16) : (!busy48 && !ov48)) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic push48(input logic [47:0] acc, input logic ovf, input int r, input int lat);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.ref_cyc = r; e.lat = lat;
        exp48.push_back(e);
    endtask

    initial begin
        int   hs, s;
        exp_t e;
        rst = 1; start = 0; abort = 0; in_valid = 0; out_ready = 1; sel = 0;
        cfg_in = 0; len_in = 0; in_a = 0; in_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy48), 64'd0);
        chk("rst_in_ready", 64'(rdy48), 64'd0);
        chk("rst_out_valid", 64'(ov48), 64'd0);
        chk("rst_mul_en", 64'(men48), 64'd0);
        chk("rst_acc", 64'(acc48), 64'd0);
        chk("rst_mul_a0", 64'(a0_48), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        // 1: SINGLE back-to-back, 3*5 + 6*4
        do_start({2'b00, MAC_SINGLE}, 16'd2, s);
        beat(32'h3, 8'd5, hs);
        beat(32'h6, 8'd4, hs);
        push48(48'd39, 1'b0, hs, 2);
        wait_idle();

        // 2: DUAL with gap, lane 2/3 must stay masked
        chk_dual = 1;
        do_start({2'b00, MAC_DUAL}, 16'd2, s);
        chk("mul_cfg_dual", 64'(mcfg48), 64'(MAC_DUAL));
        beat(32'hFFFF_0102, 8'd3, hs);
        @(posedge clk); #1;
        beat(32'hABCD_0102, 8'd3, hs);
        push48(48'd1548, 1'b0, hs, -1);
        wait_idle();
        chk_dual = 0;
        chk("dual_lane_mask", 64'(dual_viol), 64'd0);

        // 3: QUAD with output stall
        out_ready = 0;
        do_start({2'b00, MAC_QUAD}, 16'd1, s);
        beat(32'hFFFF_FFFF, 8'hFF, hs);
        push48(48'hFE_FFFF_FF01, 1'b0, hs, 2);
        for (int i = 0; i < 10 && !ov48; i++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", 64'(ov48), 64'd1);
        chk("stall_acc", 64'(acc48), 64'hFE_FFFF_FF01);
        out_ready = 1;
        @(posedge clk); #1;
        chk("post_hs_valid", 64'(ov48), 64'd0);
        chk("post_hs_busy", 64'(busy48), 64'd0);

        // 4: 16-bit accumulator wraps and flags overflow
        sel = 1;
        do_start({2'b00, MAC_SINGLE}, 16'd2, s);
        beat(32'hFF, 8'hFF, hs);
        beat(32'hFF, 8'hFF, hs);
        e.acc = 48'd64514; e.ovf = 1'b1; e.ref_cyc = hs; e.lat = 2;
        exp16.push_back(e);
        wait_idle();
        sel = 0;

        // 5: zero-length job, then unsupported cfg
        do_start({2'b00, MAC_SINGLE}, 16'd0, s);
        push48(48'd0, 1'b0, s, 1);
        wait_idle();
        start = 1; cfg_in = 4'h3; len_in = 16'd4;
        @(posedge clk); #1;
        start = 0;
        chk("cfg_err_pulse", 64'(cerr48), 64'd1);
        chk("cfg_err_busy", 64'(busy48), 64'd0);
        @(posedge clk); #1;
        chk("cfg_err_clear", 64'(cerr48), 64'd0);
        chk("cfg_err_busy2", 64'(busy48), 64'd0);

        // 6: abort after one of four beats, then a fresh job
        do_start({2'b00, MAC_SINGLE}, 16'd4, s);
        beat(32'h7, 8'd7, hs);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("abort_busy", 64'(busy48), 64'd0);
        chk("abort_in_ready", 64'(rdy48), 64'd0);
        chk("abort_mul_en", 64'(men48), 64'd0);
        chk("abort_acc", 64'(acc48), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_valid", 64'(ov48), 64'd0);
        do_start({2'b00, MAC_SINGLE}, 16'd1, s);
        beat(32'h2, 8'd2, hs);
        push48(48'd4, 1'b0, hs, 2);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb48_empty", 64'(exp48.size()), 64'd0);
        chk("sb16_empty", 64'(exp16.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
